reg_load_seq: RTL and testbench
===============================

REG_LOAD_SEQ -- requirements
Module: reg_load_seq

Interface
REQ-001 The module SHALL have parameter N, default 5, meaning key-code and data width.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of slot registers sequenced (2..8).
REQ-003 The module SHALL have parameter ENTER_CODE, default 5'h1F, meaning the code that terminates an entry.
REQ-004 The module SHALL have parameter CLEAR_CODE, default 5'h1E, meaning the code that aborts an entry.
REQ-005 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port key_valid, input, 1, level: high while a key is pressed, with key_code stable.
REQ-008 Port key_code, input, N, code of the pressed key.
REQ-009 Port load, output, DEPTH, one-hot load enables to the slot registers.
REQ-010 Port d_out, output, N, data bus to the slot registers, valid while any load bit is high.
REQ-011 Port count, output, 4, number of slots filled in the current entry (0..DEPTH).
REQ-012 Port busy, output, 1, high in any state other than IDLE.
REQ-013 Port done, output, 1, one-cycle pulse on an accepted ENTER.
REQ-014 Port clr, output, 1, one-cycle pulse on an accepted CLEAR.
REQ-015 Port err, output, 1, one-cycle pulse on a rejected digit press.

Function
REQ-016 FSM states SHALL be IDLE, LOAD and WAIT_REL.
REQ-017 IDLE with key_valid=1 SHALL classify key_code at that edge: digit (code <= 9), ENTER_CODE, CLEAR_CODE or other.
REQ-018 Digit with count<DEPTH: next cycle state=LOAD; code latched into d_out; load[count]=1 for exactly one cycle.
REQ-019 LOAD SHALL last one cycle, then go to WAIT_REL, with count incremented by 1 on exit.
REQ-020 Digit with count==DEPTH: no load; err=1 for one cycle; state goes to WAIT_REL.
REQ-021 ENTER: done=1 for one cycle; count=0 on the next cycle; no load; state goes to WAIT_REL.
REQ-022 ENTER with count==0 SHALL still pulse done.
REQ-023 CLEAR: clr=1 for one cycle; count=0 on the next cycle; no load; state goes to WAIT_REL.
REQ-024 Other codes SHALL be ignored: no pulse and no state change. IDLE re-evaluates every cycle while key_valid stays high.
REQ-025 WAIT_REL SHALL go to IDLE on the first cycle key_valid=0; one press SHALL never produce more than one action.
REQ-026 key_valid and key_code SHALL be ignored in LOAD and in WAIT_REL while key_valid=1.
REQ-027 At most one load bit SHALL be high in any cycle; load SHALL be 0 outside LOAD.
REQ-028 d_out SHALL hold its last latched value between loads.
REQ-029 done, clr and err SHALL be mutually exclusive.
REQ-030 count SHALL saturate at DEPTH and never wrap.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, load=0, d_out=0, count=0, busy=0, done=0, clr=0 and err=0, independent of clk.
REQ-032 rst asserted during LOAD SHALL cancel the load pulse at once. Slot register contents are the register bank's responsibility.
REQ-033 After rst deasserts with key_valid still high, the FSM SHALL start in IDLE and treat the held key as a new press.

Verification
REQ-034 Bench: press 3, release, press 7, release -> load=4'b0001 with d_out=3, then load=4'b0010 with d_out=7; count=2.
REQ-035 Bench: five digit presses 1,2,3,4,5 -> loads 0001..1000 with d_out 1..4; fifth press gives err pulse and no load; count=4.
REQ-036 Bench: two digits then 5'h1F -> one-cycle done pulse; count=0; next digit 9 loads slot 0 with d_out=9.
REQ-037 Bench: two digits then 5'h1E -> one-cycle clr pulse; count=0; load stays 0.
REQ-038 Bench: digit 6 held 20 cycles -> exactly one load pulse; busy high until the cycle after release.
REQ-039 Bench: rst pulsed asynchronously while load=0100 -> load=0 and count=0 before the next clk edge.

Source files
------------

// File: rtl/reg_load_seq.sv
// rtl/reg_load_seq.sv - keypad-driven sequencer that loads digits into a bank of slot registers
// One action per key press: digit -> load next slot, ENTER -> done, CLEAR -> clr.
module reg_load_seq #(
  parameter int             N          = 5,
  parameter int             DEPTH      = 4,
  parameter logic [N-1:0]   ENTER_CODE = 5'h1F,
  parameter logic [N-1:0]   CLEAR_CODE = 5'h1E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [N-1:0]     key_code,
  output logic [DEPTH-1:0] load,
  output logic [N-1:0]     d_out,
  output logic [3:0]       count,
  output logic             busy,
  output logic             done,
  output logic             clr,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [3:0]     count_nx;
  logic [N-1:0]   d_nx;
  logic           done_nx, clr_nx, err_nx;
  logic           is_digit, slots_full;

  assign is_digit   = (key_code <= N'(9));
  assign slots_full = (count >= 4'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      d_out <= '0;
      done  <= 1'b0;
      clr   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      d_out <= d_nx;
      done  <= done_nx;
      clr   <= clr_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    d_nx     = d_out;
    done_nx  = 1'b0;
    clr_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        // Unrecognised codes leave the FSM in IDLE so the held key is re-sampled every cycle.
        if (key_valid) begin
          if (is_digit) begin
            state_nx = WAIT_REL;
            if (slots_full) begin
              err_nx = 1'b1;
            end else begin
              state_nx = LOAD;
              d_nx     = key_code;
            end
          end else if (key_code == ENTER_CODE) begin
            state_nx = WAIT_REL;
            done_nx  = 1'b1;
            count_nx = '0;
          end else if (key_code == CLEAR_CODE) begin
            state_nx = WAIT_REL;
            clr_nx   = 1'b1;
            count_nx = '0;
          end
        end
      end
      LOAD: begin
        state_nx = WAIT_REL;
        count_nx = count + 4'd1;
      end
      WAIT_REL: begin
        if (!key_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops the enable without waiting for a clock.
  assign load = (state == LOAD) ? (DEPTH'(1) << count) : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_load_seq.sv
// tb/tb_reg_load_seq.sv - self-checking bench for reg_load_seq against a press-level reference model
// The model predicts the outcome of each whole key press, not the cycle-by-cycle FSM.
module tb_reg_load_seq;

  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             key_valid;
  logic [4:0]       key_code;
  logic [DEPTH-1:0] load;
  logic [4:0]       d_out;
  logic [3:0]       count;
  logic             busy, done, clr, err;

  int vectors     = 0;
  int miscompares = 0;

  // press-level reference model state
  int         m_count;
  logic [4:0] m_d;

  // per-press observations
  int         n_load, n_done, n_clr, n_err, rel_cycles, busy_drops;
  logic [3:0] load_seen;
  logic [4:0] d_seen;
  logic       first_rel_busy;

  reg_load_seq #(.N(5), .DEPTH(DEPTH), .ENTER_CODE(5'h1F), .CLEAR_CODE(5'h1E)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .load(load), .d_out(d_out), .count(count), .busy(busy),
    .done(done), .clr(clr), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit in_hold, input int idx);
    check("load_onehot0", 32'($onehot0(load)), 32'd1);
    check("pulse_exclusive", 32'(int'(done) + int'(clr) + int'(err) <= 1), 32'd1);
    if (load != '0) begin
      n_load++;
      load_seen = load;
      d_seen    = d_out;
    end
    if (done) n_done++;
    if (clr)  n_clr++;
    if (err)  n_err++;
    if (in_hold && idx > 0 && !busy) busy_drops++;
  endtask

  // Holds the key for `hold` rising edges (key already driven), releases, then waits for IDLE.
  task automatic observe(input int hold);
    n_load = 0; n_done = 0; n_clr = 0; n_err = 0; busy_drops = 0;
    load_seen = '0; d_seen = '0; rel_cycles = 0; first_rel_busy = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      sample(1'b1, i);
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    do begin
      @(negedge clk);
      sample(1'b0, 0);
      if (rel_cycles == 0) first_rel_busy = busy;
      rel_cycles++;
    end while (busy && rel_cycles < 10);
    check("release_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_press(input string tag, input logic [4:0] code, input int hold, input bit drive);
    int         e_load_n, e_done, e_clr, e_err;
    logic [3:0] e_load;
    e_load_n = 0; e_done = 0; e_clr = 0; e_err = 0; e_load = '0;
    if (code <= 5'd9) begin
      if (m_count < DEPTH) begin
        e_load_n = 1;
        e_load   = 4'(1 << m_count);
        m_d      = code;
        m_count++;
      end else begin
        e_err = 1;
      end
    end else if (code == 5'h1F) begin
      e_done = 1; m_count = 0;
    end else if (code == 5'h1E) begin
      e_clr = 1; m_count = 0;
    end
    if (drive) begin
      key_code  = code;
      key_valid = 1'b1;
    end
    observe(hold);
    check({tag, "_nload"}, 32'(n_load), 32'(e_load_n));
    check({tag, "_load"},  32'(load_seen), 32'(e_load));
    if (e_load_n == 1) check({tag, "_d_at_load"}, 32'(d_seen), 32'(code));
    check({tag, "_done"},  32'(n_done), 32'(e_done));
    check({tag, "_clr"},   32'(n_clr), 32'(e_clr));
    check({tag, "_err"},   32'(n_err), 32'(e_err));
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_d_hold"}, 32'(d_out), 32'(m_d));
  endtask

  initial begin
    logic [4:0] rc;
    int         sel;
    int         found;
    rst = 1'b1; key_valid = 1'b0; key_code = '0;
    m_count = 0; m_d = '0;
    #1;
    check("rst_load", 32'(load), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, clr, err}), 32'd0);
    check("rst_dout", 32'(d_out), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // two digits into slots 0 and 1
    do_press("p3", 5'd3, 2, 1'b1);
    do_press("p7", 5'd7, 2, 1'b1);

    // fill all slots, fifth digit overflows
    do_press("ent0", 5'h1F, 2, 1'b1);
    for (int i = 1; i <= 5; i++) do_press("fill", 5'(i), 3, 1'b1);

    // ENTER clears the count; next digit lands in slot 0
    do_press("ent1", 5'h1F, 2, 1'b1);
    do_press("d2", 5'd2, 2, 1'b1);
    do_press("d8", 5'd8, 2, 1'b1);
    do_press("ent2", 5'h1F, 2, 1'b1);
    do_press("d9", 5'd9, 2, 1'b1);

    // CLEAR after two digits, then ENTER with nothing entered
    do_press("c1", 5'd1, 1, 1'b1);
    do_press("c4", 5'd4, 1, 1'b1);
    do_press("clr", 5'h1E, 2, 1'b1);
    do_press("ent_empty", 5'h1F, 2, 1'b1);

    // long press: single load, busy until the cycle after release
    do_press("hold6", 5'd6, 20, 1'b1);
    check("hold6_busy_drops", 32'(busy_drops), 32'd0);
    check("hold6_busy_at_release", 32'(first_rel_busy), 32'd1);
    check("hold6_release_cycles", 32'(rel_cycles), 32'd2);

    // unused codes do nothing
    do_press("other_a", 5'h0A, 4, 1'b1);
    do_press("other_1d", 5'h1D, 3, 1'b1);

    // randomized press sequence
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 12);
      if (sel <= 9)       rc = 5'(sel);
      else if (sel == 10) rc = 5'h1F;
      else if (sel == 11) rc = 5'h1E;
      else                rc = 5'($urandom_range(10, 29));
      do_press("rnd", rc, $urandom_range(1, 4), 1'b1);
    end

    // asynchronous reset in the middle of a load of slot 2
    do_press("pre_ent", 5'h1F, 2, 1'b1);
    do_press("pre_d1", 5'd1, 2, 1'b1);
    do_press("pre_d2", 5'd2, 2, 1'b1);
    key_code = 5'd4; key_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      @(negedge clk);
      if (load == 4'b0100) found = 1;
    end
    check("arst_reached_load", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_load", 32'(load), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dout", 32'(d_out), 32'd0);
    #1 rst = 1'b0;
    m_count = 0; m_d = '0;
    // key still held: treated as a fresh press after reset
    do_press("post_rst", 5'd4, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
